// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter sharing one 4x4 signed Booth multiplier among NREQ requesters.
// Optional watchdog on the multiplier response is enabled by defining BOOTH_ARB_TIMEOUT_EN.
module booth_mul_arbiter #(
    parameter int NREQ    = 4,
    parameter int TMO_CYC = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [4*NREQ-1:0]        req_x,
    input  logic [4*NREQ-1:0]        req_y,
    output logic                     mul_start,
    output logic signed [3:0]        mul_x,
    output logic signed [3:0]        mul_y,
    input  logic                     mul_valid,
    input  logic signed [7:0]        mul_z,
    output logic [NREQ-1:0]          done,
    output logic signed [7:0]        res_z,
    output logic [$clog2(NREQ)-1:0]  gnt_id,
    output logic                     busy,
    output logic                     err
);

    localparam int PTR_W = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TMO_CYC < 1) begin : g_bad_param
        $error("booth_mul_arbiter: NREQ must be 2..8 and TMO_CYC >= 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t                r_state;
    logic [PTR_W-1:0]      r_ptr;
    logic [PTR_W-1:0]      r_gnt;
    logic                  r_start;
    logic                  r_busy;
    logic signed [3:0]     r_x;
    logic signed [3:0]     r_y;
    logic [NREQ-1:0]       r_done;
    logic signed [7:0]     r_z;

    logic                  w_found;
    logic [PTR_W-1:0]      w_gnt;
    logic [PTR_W-1:0]      w_idx;
    logic [PTR_W:0]        w_sum;
    logic [PTR_W-1:0]      w_ptr_nxt;
    logic [3:0]            w_x;
    logic [3:0]            w_y;
    logic [NREQ-1:0]       w_onehot;

    // Scan from ptr upward, wrapping at NREQ, and take the first active request.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
            if (w_sum >= (PTR_W+1)'(NREQ))
                w_sum = w_sum - (PTR_W+1)'(NREQ);
            w_idx = w_sum[PTR_W-1:0];
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_gnt   = w_idx;
            end
        end
    end

    assign w_ptr_nxt = (w_gnt == PTR_W'(NREQ-1)) ? '0 : w_gnt + 1'b1;
    assign w_x       = req_x[{w_gnt, 2'b00} +: 4];
    assign w_y       = req_y[{w_gnt, 2'b00} +: 4];
    assign w_onehot  = {{(NREQ-1){1'b0}}, 1'b1} << r_gnt;

`ifdef BOOTH_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);
    logic [TMO_W-1:0] r_tmo;
    logic             r_err;
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_done  <= '0;
            r_z     <= '0;
`ifdef BOOTH_ARB_TIMEOUT_EN
            r_tmo   <= '0;
            r_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_x     <= w_x;
                        r_y     <= w_y;
                        r_gnt   <= w_gnt;
                        r_ptr   <= w_ptr_nxt;
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_start <= 1'b0;
                    r_state <= S_WAIT;
`ifdef BOOTH_ARB_TIMEOUT_EN
                    r_tmo   <= '0;
`endif
                end
                S_WAIT: begin
                    if (mul_valid) begin
                        r_z     <= mul_z;
                        r_done  <= w_onehot;
                        r_state <= S_DONE;
                    end
`ifdef BOOTH_ARB_TIMEOUT_EN
                    // Silent multiplier: release the requester with a zero result and flag it.
                    else if (r_tmo == TMO_W'(TMO_CYC - 1)) begin
                        r_z     <= '0;
                        r_done  <= w_onehot;
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_tmo   <= r_tmo + 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    r_done  <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
`ifdef BOOTH_ARB_TIMEOUT_EN
                    r_err   <= 1'b0;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mul_start = r_start;
    assign mul_x     = r_x;
    assign mul_y     = r_y;
    assign done      = r_done;
    assign res_z     = r_z;
    assign gnt_id    = r_gnt;
    assign busy      = r_busy;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed bench for booth_mul_arbiter with a two-cycle multiplier stub.
module tb_booth_mul_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] req_x;
    logic [15:0] req_y;
    logic        mul_start;
    logic [3:0]  mul_x;
    logic [3:0]  mul_y;
    logic        mul_valid;
    logic [7:0]  mul_z;
    logic [3:0]  done;
    logic [7:0]  res_z;
    logic [1:0]  gnt_id;
    logic        busy;
    logic        err;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_start = 0;
    int overlap = 0;
    int outst = 0;
    int seen;
    int busy_lo;
    int n0;
    int c0;

    logic              stub_en;
    logic              stub_valid = 1'b0;
    logic [7:0]        stub_z = 8'h00;
    logic signed [7:0] stub_prod = 8'sh00;
    int                stub_cnt = 0;
    logic              man_valid;
    logic [7:0]        man_z;

    int exp_g [5] = '{0, 1, 2, 3, 0};
    int exp_z [5] = '{8'h07, 8'hF1, 8'hC8, 8'h01, 8'h07};

    assign mul_valid = stub_valid | man_valid;
    assign mul_z     = man_valid ? man_z : stub_z;

    booth_mul_arbiter #(.NREQ(4), .TMO_CYC(16)) dut (
        .clk(clk), .rst(rst), .req(req), .req_x(req_x), .req_y(req_y),
        .mul_start(mul_start), .mul_x(mul_x), .mul_y(mul_y),
        .mul_valid(mul_valid), .mul_z(mul_z), .done(done), .res_z(res_z),
        .gnt_id(gnt_id), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Multiplier stub: answers two negedges after seeing mul_start.
    always @(negedge clk) begin
        stub_valid = 1'b0;
        if (!rst) stub_cnt = 0;
        if (stub_cnt > 0) begin
            stub_cnt--;
            if (stub_cnt == 0) begin
                stub_valid = 1'b1;
                stub_z     = stub_prod;
            end
        end
        if (mul_start && stub_en && rst) begin
            stub_cnt  = 2;
            stub_prod = $signed(mul_x) * $signed(mul_y);
        end
    end

    always @(negedge clk) begin
        if (!rst || !busy) outst = 0;
        if (mul_start) begin
            n_start++;
            if (outst != 0) overlap++;
            outst = 1;
        end
        if (done != 0) outst = 0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [3:0] x, input logic [3:0] y);
        req_x[4*i +: 4] = x;
        req_y[4*i +: 4] = y;
    endtask

    task automatic wait_done(input string tag);
        seen    = 0;
        busy_lo = 0;
        for (int k = 0; k < 60 && seen == 0; k++) begin
            @(negedge clk);
            if (done != 0) seen = 1;
            else if (!busy) busy_lo++;
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  32'(busy),      32'd0);
        check({tag, "_start"}, 32'(mul_start), 32'd0);
        check({tag, "_done"},  32'(done),      32'd0);
        check({tag, "_res"},   32'(res_z),     32'd0);
        check({tag, "_gnt"},   32'(gnt_id),    32'd0);
        check({tag, "_mulx"},  32'(mul_x),     32'd0);
        check({tag, "_muly"},  32'(mul_y),     32'd0);
        check({tag, "_err"},   32'(err),       32'd0);
    endtask

    initial begin
        rst = 1'b0; req = '0; req_x = '0; req_y = '0;
        stub_en = 1'b1; man_valid = 1'b0; man_z = '0;
        repeat (3) @(negedge clk);
        check_all_zero("rst");
        rst = 1'b1;
        @(negedge clk);

        // All four held: strict rotation starting from index 0.
        set_op(0, 4'h1, 4'h7); set_op(1, 4'hD, 4'h5);
        set_op(2, 4'h7, 4'h8); set_op(3, 4'hF, 4'hF);
        req = 4'hF;
        for (int n = 0; n < 5; n++) begin
            wait_done("rr");
            check("rr_gnt",  32'(gnt_id), 32'(exp_g[n]));
            check("rr_done", 32'(done),   32'd1 << exp_g[n]);
            check("rr_res",  32'(res_z),  32'(exp_z[n]));
            check("rr_err",  32'(err),    32'd0);
        end
        req = 4'h0;
        check("rr_overlap", 32'(overlap), 32'd0);
        @(negedge clk);
        check("rr_done_1cyc", 32'(done), 32'd0);
        check("rr_idle", 32'(busy), 32'd0);

        // Single request from requester 2: 3 * -2 = -6.
        set_op(2, 4'h3, 4'hE);
        n0  = n_start;
        req = 4'b0100;
        @(negedge clk);
        check("s1_start", 32'(mul_start), 32'd1);
        check("s1_x",     32'(mul_x),     32'h3);
        check("s1_y",     32'(mul_y),     32'hE);
        check("s1_gnt",   32'(gnt_id),    32'd2);
        @(negedge clk);
        check("s1_start_1cyc", 32'(mul_start), 32'd0);
        check("s1_x_hold",     32'(mul_x),     32'h3);
        wait_done("s1");
        check("s1_done", 32'(done),  32'b0100);
        check("s1_res",  32'(res_z), 32'hFA);
        check("s1_nstart", 32'(n_start - n0), 32'd1);
        req = 4'h0;
        @(negedge clk);
        check("s1_res_hold", 32'(res_z), 32'hFA);
        check("s1_done_off", 32'(done),  32'd0);

        // Only requester 3 active: granted, then granted again after ptr wraps to 0.
        req = 4'b1000;
        wait_done("w1");
        check("w1_gnt", 32'(gnt_id), 32'd3);
        wait_done("w2");
        check("w2_gnt", 32'(gnt_id), 32'd3);
        check("w2_res", 32'(res_z),  32'h01);
        set_op(0, 4'h8, 4'h8);
        req = 4'b1001;
        @(negedge clk);
        check("w_idle", 32'(busy), 32'd0);

        // ptr is 0, so requester 0 wins over 3: -8 * -8 = 64.
        wait_done("m8");
        check("m8_gnt",    32'(gnt_id),  32'd0);
        check("m8_done",   32'(done),    32'b0001);
        check("m8_res",    32'(res_z),   32'h40);
        check("m8_busylo", 32'(busy_lo), 32'd0);
        check("m8_busy_done", 32'(busy), 32'd1);
        req = 4'h0;
        @(negedge clk);
        check("m8_busy_end", 32'(busy), 32'd0);

        // Reset while stuck in WAIT; stale mul_valid afterwards must be ignored.
        stub_en = 1'b0;
        req = 4'b0101;
        repeat (4) @(negedge clk);
        check("rw_gnt",  32'(gnt_id), 32'd2);
        check("rw_busy", 32'(busy),   32'd1);
        rst = 1'b0;
        #1;
        check_all_zero("rw_rst");
        @(negedge clk);
        rst = 1'b1;
        req = 4'h0;
        @(negedge clk);
        man_z = 8'h55; man_valid = 1'b1;
        @(negedge clk);
        man_valid = 1'b0;
        check("stale_done", 32'(done),  32'd0);
        check("stale_res",  32'(res_z), 32'd0);
        check("stale_busy", 32'(busy),  32'd0);
        stub_en = 1'b1;
        req = 4'b0110;
        @(negedge clk);
        check("rr2_start", 32'(mul_start), 32'd1);
        check("rr2_gnt",   32'(gnt_id),    32'd1);
        wait_done("rr2");
        check("rr2_done", 32'(done),  32'b0010);
        check("rr2_res",  32'(res_z), 32'hF1);
        req = 4'h0;
        @(negedge clk);

`ifdef BOOTH_ARB_TIMEOUT_EN
        // Silent multiplier: done+err 16 cycles after WAIT is entered.
        stub_en = 1'b0;
        req = 4'b0001;
        @(negedge clk);
        c0 = cyc;
        wait_done("tmo");
        check("tmo_lat",  32'(cyc - c0), 32'd17);
        check("tmo_done", 32'(done),     32'b0001);
        check("tmo_err",  32'(err),      32'd1);
        check("tmo_res",  32'(res_z),    32'd0);
        req = 4'h0;
        @(negedge clk);
        check("tmo_err_off", 32'(err), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
